pc_fetch_unit: RTL
==================

# pc_fetch_unit

Parametrised program-counter and instruction-fetch unit for the processor front end. Holds the PC, computes the next address (increment, absolute load, PC-relative branch, call/return), fetches each instruction over a request/acknowledge memory port, and presents it to decode through a valid/ready handshake. It generalises the earlier increment/load/reset PC in three ways: configurable width and reset vector, a real fetch handshake, and an optional return-address stack.

## Interface
- `N`, default 32: address and instruction width.
- `RESET_VECTOR`, default 0: PC value after reset.
- `STEP`, default 1: increment per instruction (word addressing).
- `RAS_DEPTH`, default 4: return-address stack entries (power of two, ≥ 2); only used with `PC_FETCH_RAS_EN`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `inc`  in  1  advance PC by `STEP`.
- `load`  in  1  PC <= `in`.
- `in`  in  N  absolute target for `load` / `call`.
- `branch`  in  1  PC <= PC + `offset`.
- `offset`  in  N  two's-complement branch offset.
- `call`  in  1  push PC+`STEP`, then PC <= `in`.
- `ret`  in  1  PC <= popped return address.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  N  fetch address (equals `pc`).
- `mem_ack`  in  1  memory returns `mem_data` this cycle.
- `mem_data`  in  N  fetched instruction word.
- `instruction`  out  N  registered instruction to decode.
- `instr_valid`  out  1  `instruction` is valid.
- `instr_ready`  in  1  decode accepts `instruction`.
- `pc`  out  N  address of the current instruction.
- `ras_overflow`  out  1  sticky: push onto a full stack.
- `ras_underflow`  out  1  sticky: pop from an empty stack.

## Operation
- FSM states:
  - START: post-reset idle, lasts one cycle, then FETCH.
  - FETCH: `mem_req`=1. On `mem_ack`, capture `mem_data` into `instruction` and go to HOLD.
  - HOLD: `instr_valid`=1. On `instr_ready`, update the PC and go to FETCH.
- Control inputs (`inc`, `load`, `branch`, `call`, `ret`) are sampled only in the HOLD & `instr_ready` cycle and ignored otherwise.
- Next-PC priority: `load` > `branch` > `ret` > `call` > `inc` > none.
  - If none is asserted, the PC holds and the same address is refetched.
- Arithmetic is modulo 2^N; `pc + STEP` and `pc + offset` wrap silently.
- Reset values:
  - State = START, `pc` = `RESET_VECTOR`, `instruction` = 0.
  - `instr_valid` = 0, `mem_req` = 0.
  - `ras_overflow` = `ras_underflow` = 0; stack pointer = 0, stack entries = 0.
- Reset asserted mid-fetch or mid-HOLD aborts immediately. A pending `mem_ack` after reset deassertion is ignored until FETCH is re-entered.
- `mem_ack` outside FETCH is ignored.

## Timing
- `mem_addr`, `mem_req`, `instr_valid` and `pc` are decoded from registered state; there is no combinational path from inputs to these outputs.
- Reset release at edge 0: START in cycle 0, FETCH from cycle 1 with `mem_addr` = `RESET_VECTOR`.
- Zero-wait memory (`mem_ack` in the first FETCH cycle): `instr_valid` rises the next cycle. Peak throughput is 1 instruction per 2 cycles.
- Back-pressure: `instruction` and `pc` stay stable while `instr_valid` & !`instr_ready`.
- New PC is visible on `mem_addr` in the cycle after the accepting HOLD cycle.

## Configuration
- `PC_FETCH_RAS_EN` defined: a `RAS_DEPTH`-entry circular return-address stack is built.
  - `call` pushes PC+`STEP`.
  - `ret` pops into PC.
  - Push when full overwrites the oldest entry and sets `ras_overflow`.
  - Pop when empty sets `ras_underflow` and behaves as `inc`.
  - `call` and `ret` in the same accepting cycle: `ret` wins and no push occurs.
- `PC_FETCH_RAS_EN` undefined: no stack storage.
  - `call` behaves as `load`.
  - `ret` is ignored; priority falls through to `inc`/none.
  - `ras_overflow` and `ras_underflow` are tied to 0.

## Test plan
- Reset with `RESET_VECTOR`=0x100, `mem_ack` always 1, `inc` held, `instr_ready`=1 → `mem_addr` sequence 0x100, 0x101, 0x102, one address per 2 cycles; `instr_valid`=0 during reset and START.
- `branch` with `offset`=0xFFFFFFFE at `pc`=0x1 → next `mem_addr` = 0xFFFFFFFF (wrap). `load`+`branch` together with `in`=0x40 → 0x40.
- `mem_ack` delayed 3 cycles and `instr_ready` low for 4 cycles in HOLD → `mem_req` held for 4 cycles; `instruction`/`pc` stable; control inputs toggled during the stall have no effect.
- With `PC_FETCH_RAS_EN`, `RAS_DEPTH`=4: 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_overflow`=1. Then 4 rets → PCs 0x51, 0x41, 0x31, 0x21. A 5th ret → `ras_underflow`=1 and PC advances by `STEP`.
- Without `PC_FETCH_RAS_EN`: `call` with `in`=0x80 → PC=0x80; `ret`+`inc` → PC+1; both flags remain 0.
- Reset asserted during HOLD with `instr_valid`=1 → `instr_valid`, `mem_req` drop in the same cycle; `pc`=`RESET_VECTOR`; fetch restarts 2 cycles after release.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: START/FETCH/HOLD sequencer with a req/ack memory port
// and valid/ready decode output. Define PC_FETCH_RAS_EN to build the circular return-address stack.
module pc_fetch_unit #(
   parameter int           N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = '0,
   parameter int           STEP         = 1,
   parameter int           RAS_DEPTH    = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         load,
   input  logic [N-1:0] in,
   input  logic         branch,
   input  logic [N-1:0] offset,
   input  logic         call,
   input  logic         ret,
   output logic         mem_req,
   output logic [N-1:0] mem_addr,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_data,
   output logic [N-1:0] instruction,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [N-1:0] pc,
   output logic         ras_overflow,
   output logic         ras_underflow,
   output logic [1:0]   dbg_state
);

   // Handshakes: a fetch completes on a cycle with mem_req & mem_ack; an instruction is
   // handed to decode on a cycle with instr_valid & instr_ready. Both are edge-sampled.
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [N-1:0] STEP_C = N'(STEP);

   state_t       state_q;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] instr_q;
   logic         mem_req_q;
   logic         valid_q;
   logic         accept;
   logic [N-1:0] pc_inc;

`ifdef PC_FETCH_RAS_EN
   localparam int            PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(RAS_DEPTH);

   logic [N-1:0]  ras_q [RAS_DEPTH];
   logic [PW-1:0] sp_q;
   logic [PW-1:0] sp_prev;
   logic [PW:0]   cnt_q;
   logic          ovf_q, unf_q;
   logic          ras_empty, ras_full;
   logic          push, pop;

   assign sp_prev   = sp_q - PTR_ONE;
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == CNT_FULL);
`else
   logic unused_ret;
   localparam int unused_ras_depth = RAS_DEPTH;
   assign unused_ret = ret;
`endif

   assign accept = (state_q == ST_HOLD) && instr_ready;
   assign pc_inc = pc_q + STEP_C;

   always_comb begin
      pc_d = pc_q;
`ifdef PC_FETCH_RAS_EN
      push = 1'b0;
      pop  = 1'b0;
`endif
      if (accept) begin
         if (load) begin
            pc_d = in;
         end else if (branch) begin
            pc_d = pc_q + offset;
`ifdef PC_FETCH_RAS_EN
         end else if (ret) begin
            // An empty stack falls back to sequential flow.
            pop  = 1'b1;
            pc_d = ras_empty ? pc_inc : ras_q[sp_prev];
         end else if (call) begin
            push = 1'b1;
            pc_d = in;
`else
         end else if (call) begin
            pc_d = in;
`endif
         end else if (inc) begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_START;
         pc_q      <= RESET_VECTOR;
         instr_q   <= '0;
         mem_req_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            ST_START: begin
               state_q   <= ST_FETCH;
               mem_req_q <= 1'b1;
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  instr_q   <= mem_data;
                  state_q   <= ST_HOLD;
                  mem_req_q <= 1'b0;
                  valid_q   <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  state_q   <= ST_FETCH;
                  mem_req_q <= 1'b1;
                  valid_q   <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_START;
               mem_req_q <= 1'b0;
               valid_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_FETCH_RAS_EN
   // Circular stack: a push onto a full stack overwrites the oldest slot, so the count saturates.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (push) begin
         ras_q[sp_q] <= pc_inc;
         sp_q        <= sp_q + PTR_ONE;
         if (ras_full) begin
            ovf_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (pop) begin
         if (ras_empty) begin
            unf_q <= 1'b1;
         end else begin
            sp_q  <= sp_prev;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
`else
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   assign mem_req     = mem_req_q;
   assign mem_addr    = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign dbg_state   = state_q;

endmodule
